// File: rtl/motor_pwm_state_ctrl.sv
// Motor PWM state controller: two debounced buttons step or clear a 5-level
// duty state, and a free-running counter turns that state into a motor PWM.
// Optional feature macro: AUTO_OFF_EN. When it is defined, an inactivity timer
// forces the state back to off and pulses o_auto_off.
module motor_pwm_state_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned PWM_PERIOD      = 1000,
  parameter int unsigned AUTO_OFF_CYCLES = 500_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_btn_up,
  input  logic       i_btn_off,
  output logic [2:0] o_pwm_state,
  output logic       o_pwm,
  output logic       o_auto_off
);

  typedef enum logic [2:0] {
    ST_OFF = 3'd0,
    ST_25  = 3'd1,
    ST_50  = 3'd2,
    ST_75  = 3'd3,
    ST_100 = 3'd4
  } state_t;

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(PWM_PERIOD);
  localparam int unsigned THR_W   = $clog2(PWM_PERIOD + 1);
  localparam int unsigned QTR     = PWM_PERIOD / 4;
  localparam int unsigned BTN_UP  = 0;
  localparam int unsigned BTN_OFF = 1;

  // Reject parameter sets the logic cannot represent
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if ((PWM_PERIOD < 4) || ((PWM_PERIOD % 4) != 0)) begin : g_bad_period
    $error("PWM_PERIOD must be a multiple of 4 and at least 4");
  end
  if (AUTO_OFF_CYCLES < 2) begin : g_bad_auto_off
    $error("AUTO_OFF_CYCLES must be at least 2");
  end

  logic [1:0]      btn_raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      level;
  logic [1:0]      level_prev;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];

  state_t          state;

  logic [CNT_W-1:0] pwm_cnt;
  logic [THR_W-1:0] thr;
  logic             pwm_q;
  logic             period_end_c;
  logic [CNT_W-1:0] cnt_next_c;
  logic [THR_W-1:0] duty_c;
  logic [THR_W-1:0] thr_next_c;

  assign btn_raw = {i_btn_off, i_btn_up};

  // Two-flop synchronizer for both raw buttons
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive mismatches;
  // press pulses one cycle after the accepted level rises
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      level      <= '0;
      level_prev <= '0;
      press      <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      level_prev <= level;
      press      <= level & ~level_prev;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

`ifdef AUTO_OFF_EN
  localparam int unsigned TM_W = $clog2(AUTO_OFF_CYCLES);

  logic [TM_W-1:0] idle_cnt;
  logic            auto_off_q;
  logic            idle_expired_c;

  assign idle_expired_c = (idle_cnt == TM_W'(AUTO_OFF_CYCLES - 1)) && (state != ST_OFF);
  assign o_auto_off     = auto_off_q;
`else
  assign o_auto_off = 1'b0;
`endif

  // Duty state machine: off beats up, up wraps 100% to off, illegal codes recover to off
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= ST_OFF;
`ifdef AUTO_OFF_EN
      idle_cnt   <= '0;
      auto_off_q <= 1'b0;
`endif
    end else begin
`ifdef AUTO_OFF_EN
      auto_off_q <= 1'b0;
`endif
      if (press[BTN_OFF]) begin
        state <= ST_OFF;
      end else if (press[BTN_UP]) begin
        case (state)
          ST_OFF:  state <= ST_25;
          ST_25:   state <= ST_50;
          ST_50:   state <= ST_75;
          ST_75:   state <= ST_100;
          ST_100:  state <= ST_OFF;
          default: state <= ST_OFF;
        endcase
      end else if (state > ST_100) begin
        state <= ST_OFF;
`ifdef AUTO_OFF_EN
      end else if (idle_expired_c) begin
        state      <= ST_OFF;
        auto_off_q <= 1'b1;
`endif
      end
`ifdef AUTO_OFF_EN
      if ((|press) || (state == ST_OFF) || idle_expired_c) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TM_W'(1);
      end
`endif
    end
  end

  assign o_pwm_state = state;

  // Next counter value and threshold; a new duty is only picked up at the period wrap
  always_comb begin
    period_end_c = (pwm_cnt == CNT_W'(PWM_PERIOD - 1));
    cnt_next_c   = period_end_c ? '0 : (pwm_cnt + CNT_W'(1));
    case (state)
      ST_25:   duty_c = THR_W'(QTR);
      ST_50:   duty_c = THR_W'(2 * QTR);
      ST_75:   duty_c = THR_W'(3 * QTR);
      ST_100:  duty_c = THR_W'(PWM_PERIOD);
      default: duty_c = '0;
    endcase
    thr_next_c = period_end_c ? duty_c : thr;
  end

  // PWM counter, latched threshold and registered output aligned to the counter
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pwm_cnt <= '0;
      thr     <= '0;
      pwm_q   <= 1'b0;
    end else begin
      pwm_cnt <= cnt_next_c;
      thr     <= thr_next_c;
      pwm_q   <= (THR_W'(cnt_next_c) < thr_next_c);
    end
  end

  assign o_pwm = pwm_q;

endmodule

// File: tb/tb_motor_pwm_state_ctrl.sv
// Bench for motor_pwm_state_ctrl with small parameters; a behavioural model
// tracks state, PWM and auto-off, and directed literals pin the model.
module tb_motor_pwm_state_ctrl;

  localparam int D = 4;
  localparam int P = 8;
  localparam int A = 64;

  logic       clk;
  logic       rst_n;
  logic       btn_up;
  logic       btn_off;
  logic [2:0] pwm_state;
  logic       pwm;
  logic       auto_off;

  int n_checks;
  int n_errors;

  motor_pwm_state_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .PWM_PERIOD     (P),
    .AUTO_OFF_CYCLES(A)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_btn_up   (btn_up),
    .i_btn_off  (btn_off),
    .o_pwm_state(pwm_state),
    .o_pwm      (pwm),
    .o_auto_off (auto_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_valid;
  int m_state, m_timer, m_pos, m_duty;
  bit m_pwm, m_ao;
  bit raw_d1 [2];
  bit raw_d2 [2];
  bit m_lvl  [2];
  bit rose_prev [2];
  bit m_ev   [2];
  int m_run  [2];

  always @(posedge clk) begin
    bit raw [2];
    int s_old;
    bit pressed;
    raw[0] = btn_up;
    raw[1] = btn_off;
    if (!rst_n) begin
      m_valid = 1'b1;
      m_state = 0; m_timer = 0; m_pos = 0; m_duty = 0;
      m_pwm = 1'b0; m_ao = 1'b0;
      for (int b = 0; b < 2; b++) begin
        raw_d1[b] = 0; raw_d2[b] = 0; m_lvl[b] = 0;
        rose_prev[b] = 0; m_ev[b] = 0; m_run[b] = 0;
      end
    end else begin
      s_old   = m_state;
      pressed = m_ev[0] | m_ev[1];
      m_ao    = 1'b0;
      if (m_ev[1]) m_state = 0;
      else if (m_ev[0]) m_state = (m_state + 1) % 5;
`ifdef AUTO_OFF_EN
      else if (s_old != 0 && m_timer == A - 1) begin
        m_state = 0;
        m_ao    = 1'b1;
      end
      if (pressed || s_old == 0 || m_ao) m_timer = 0;
      else m_timer++;
`endif
      m_pos = (m_pos + 1) % P;
      if (m_pos == 0) m_duty = s_old;
      m_pwm = (m_pos < m_duty * P / 4);
      // A button level is accepted after D consecutive differing synchronized
      // samples; the state sees the press two edges after that acceptance.
      for (int b = 0; b < 2; b++) begin
        m_ev[b]      = rose_prev[b];
        rose_prev[b] = 1'b0;
        if (raw_d2[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_lvl[b]     = raw_d2[b];
            m_run[b]     = 0;
            rose_prev[b] = m_lvl[b];
          end
        end else begin
          m_run[b] = 0;
        end
        raw_d2[b] = raw_d1[b];
        raw_d1[b] = raw[b];
      end
    end
  end

  // Continuous comparison of all outputs against the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("state", int'(pwm_state), m_state);
      check("pwm", int'(pwm), int'(m_pwm));
      check("auto_off", int'(auto_off), int'(m_ao));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; btn_up = 1'b0; btn_off = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  task automatic press_up();
    btn_up = 1'b1; step(6);
    btn_up = 1'b0; step(8);
  endtask

  task automatic count_high(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      c += int'(pwm);
    end
  endtask

  initial begin
    int c;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; btn_up = 1'b0; btn_off = 1'b0;

    // Reset values
    step(3);
    check("rst_state", int'(pwm_state), 0);
    check("rst_pwm", int'(pwm), 0);
    check("rst_auto_off", int'(auto_off), 0);

    // Held button after reset: one step exactly D+4 edges later, no repeat
    rst_n = 1'b1; btn_up = 1'b1;
    step(7);
    check("hold_before", int'(pwm_state), 0);
    step(1);
    check("hold_step", int'(pwm_state), 1);
    step(20);
    check("hold_no_repeat", int'(pwm_state), 1);
    btn_up = 1'b0; step(10);
    press_up();
    check("second_press", int'(pwm_state), 2);

    // Five presses walk through all states and wrap
    do_reset();
    press_up(); check("walk1", int'(pwm_state), 1);
    press_up(); check("walk2", int'(pwm_state), 2);
    step(8); count_high(P, c);
    check("duty50_highs", c, 4);
    press_up(); check("walk3", int'(pwm_state), 3);
    press_up(); check("walk4", int'(pwm_state), 4);
    step(8); count_high(P, c);
    check("duty100_highs", c, 8);
    press_up(); check("walk5", int'(pwm_state), 0);

    // Short bounces never produce an event
    do_reset();
    for (int i = 0; i < 10; i++) begin
      btn_up = 1'b1; step(1);
      btn_up = 1'b0; step(2);
    end
    step(10);
    check("bounce_state", int'(pwm_state), 0);

    // Simultaneous up and off events: off wins
    do_reset();
    press_up(); press_up(); press_up();
    check("at_75", int'(pwm_state), 3);
    btn_up = 1'b1; btn_off = 1'b1; step(6);
    btn_up = 1'b0; btn_off = 1'b0; step(8);
    check("both_state", int'(pwm_state), 0);
    step(8); count_high(P, c);
    check("both_pwm_highs", c, 0);

    // Duty change mid-period waits for the counter wrap
    do_reset();
    press_up();
    for (int i = 0; i < P && m_pos != 2; i++) step(1);
    check("align_pos", m_pos, 2);
    btn_up = 1'b1; step(6);
    btn_up = 1'b0; step(2);
    check("mid_state", int'(pwm_state), 2);
    check("mid_pos2_old", int'(pwm), 0);
    step(1); check("mid_pos3_old", int'(pwm), 0);
    step(5); check("mid_pos0_new", int'(pwm), 1);
    step(3); check("mid_pos3_new", int'(pwm), 1);
    step(1); check("mid_pos4_new", int'(pwm), 0);

    // Inactivity behaviour
    do_reset();
    press_up();
`ifdef AUTO_OFF_EN
    step(57);
    check("ao_before_state", int'(pwm_state), 1);
    check("ao_before_pulse", int'(auto_off), 0);
    step(1);
    check("ao_state", int'(pwm_state), 0);
    check("ao_pulse", int'(auto_off), 1);
    step(1);
    check("ao_pulse_end", int'(auto_off), 0);
`else
    step(200);
    check("noao_state", int'(pwm_state), 1);
    check("noao_pulse", int'(auto_off), 0);
`endif

    // Randomized button activity with occasional resets
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset();
      end else begin
        btn_up  = ($urandom_range(0, 2) != 0);
        btn_off = ($urandom_range(0, 5) == 0);
        step($urandom_range(1, 12));
      end
    end
    btn_up = 1'b0; btn_off = 1'b0;
    step(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/motor_pwm_state_ctrl.md
Name: motor_pwm_state_ctrl

Overview:
- Produces the 3-bit PWM state code (0..4) that the LED bar and motor driver consume, and generates the motor PWM waveform for that state.
- Two push buttons are debounced: "up" steps the duty level and wraps to off; "off" forces the off state.
- An optional inactivity timer returns the motor to off.
- Sits between the board buttons and the LED/motor outputs.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: clocks a synchronized button level must hold before it is accepted. Must be ≥2.
- PWM_PERIOD, 1000: PWM period in clocks. Must be a multiple of 4 and ≥4.
- AUTO_OFF_CYCLES, 500_000_000: inactivity clocks before forced off. Used only with AUTO_OFF_EN.

Ports:
- i_clk  input  1  system clock
- i_reset_n  input  1  synchronous, active-low reset
- i_btn_up  input  1  raw asynchronous button, active-high; advances state
- i_btn_off  input  1  raw asynchronous button, active-high; forces off
- o_pwm_state  output  3  current state code: 000=off, 001=25%, 010=50%, 011=75%, 100=100%
- o_pwm  output  1  registered motor PWM
- o_auto_off  output  1  one-cycle pulse when the timer forces off; constant 0 without AUTO_OFF_EN

Behaviour:
- Reset (i_reset_n=0 at a rising edge):
  - o_pwm_state=000, o_pwm=0, o_auto_off=0.
  - All sync flops, debounce counters, debounced levels, PWM counter, latched duty and timer cleared.
  - Reset mid-press discards the press. A button still held after reset must re-debounce; the debounced level starts at 0, so a held button produces one event DEBOUNCE_CYCLES+4 clocks after reset release.
- Synchronizer: each button passes through 2 flops.
- Debounce, per button:
  - Counter resets to 0 whenever the sync output equals the debounced level; otherwise it increments.
  - When the counter is at DEBOUNCE_CYCLES-1 and the mismatch persists, the debounced level takes the sync value and the counter clears.
  - Press event is a registered one-cycle pulse, set the cycle after the debounced level rises 0→1. Release generates no event.
- Latency: raw level held from just before edge 1 → o_pwm_state changes at edge DEBOUNCE_CYCLES+4.
- Glitch rejection: a bounce shorter than DEBOUNCE_CYCLES sync cycles produces no event.
- State FSM, registered, drives o_pwm_state directly:
  - Up event: 000→001→010→011→100→000 (wrap).
  - Off event: any state→000.
  - Up and off events in the same cycle: off wins.
  - No event: hold.
  - Illegal codes 101–111 (e.g. SEU): go to 000 on the next edge.
- PWM:
  - Free-running counter 0..PWM_PERIOD-1, wraps to 0.
  - Duty threshold = state × PWM_PERIOD/4. Integer constants only; no runtime divide.
  - Threshold is latched when the counter is at PWM_PERIOD-1, so a new state takes effect at the next period start. No partial-period glitch.
  - o_pwm is registered and equals (counter < latched threshold).
  - State 000 → 0% (constant 0). State 100 → 100% (constant 1).

Optional Feature:
- Macro: AUTO_OFF_EN.
- When defined:
  - An inactivity counter reloads to 0 on any press event and whenever the state is 000.
  - It otherwise increments while the state is non-zero.
  - On reaching AUTO_OFF_CYCLES-1: the next edge sets the state to 000 and o_auto_off=1 for exactly one cycle. The counter clears.
  - A press event arriving in that same cycle takes priority: the FSM handles the event normally, the counter reloads, and there is no auto-off pulse.
- When undefined: no timer logic is synthesized, o_auto_off is tied to 0, and the state persists indefinitely.

Test Plan (DEBOUNCE_CYCLES=4, PWM_PERIOD=8, AUTO_OFF_CYCLES=64):
- Reset, then hold i_btn_up high continuously → o_pwm_state 000→001 exactly 8 clocks after the first sample, and no further step while held. Release, then press again → 010.
- Five clean up presses from 000 → states 001,010,011,100,000. With the state at 010, o_pwm is high for 4 of every 8 clocks once the next period begins; at 100 it is constant 1.
- Bounce on i_btn_up of 1-clock high pulses every 3 clocks for 30 clocks → state unchanged.
- At state 011, raise up and off so that both events pulse in the same cycle → state 000, o_pwm=0 from the next PWM period.
- Press up at PWM counter value 2 → o_pwm keeps the old duty until the counter wraps to 0, then uses the new duty.
- With AUTO_OFF_EN, at state 001 with no presses → after 64 clocks, state 000 and o_auto_off high for exactly 1 cycle. Without the macro → state stays 001 and o_auto_off stays 0 for 200 clocks.
